punc_exec_unit: RTL and testbench
=================================

PUNC_EXEC_UNIT -- requirements
Module: punc_exec_unit

Interface
REQ-001 Parameter WIDTH, default 16, datapath/register width (>=4, power of 2).
REQ-002 Parameter NREGS, default 8, register count (power of 2); AW = clog2(NREGS), SW = clog2(WIDTH) derived.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; accepted only in IDLE.
REQ-006 op  input  3  000 ADD, 001 AND, 010 NOT, 011 PASS_A, 100 MUL, 101 SLL, 110 SRA, 111 reserved.
REQ-007 src_a, src_b, dst  input  AW each  operand/destination register indices.
REQ-008 imm  input  WIDTH  immediate, pre-sign-extended by controller.
REQ-009 imm_sel  input  1  1: operand B = imm; 0: operand B = RF[src_b].
REQ-010 wb_en  input  1  1: write result to RF[dst] and update NZP.
REQ-011 flush  input  1  synchronous abort of an in-flight operation.
REQ-012 busy  output  1  high in EXEC and DONE.
REQ-013 done  output  1  one-cycle completion pulse (high in DONE).
REQ-014 result  output  WIDTH  last completed result, held until next completion.
REQ-015 n, z, p  output  1 each  condition codes, exactly one high at all times.
REQ-016 dbg_addr  input  AW; dbg_data  output  WIDTH  combinational RF[dbg_addr].

Function
REQ-017 FSM states IDLE, EXEC, DONE; DONE always returns to IDLE on the next edge.
REQ-018 Accept edge = rising edge with state IDLE, start=1, flush=0; op, dst, wb_en, A=RF[src_a], B (per imm_sel) latched at that edge.
REQ-019 start outside IDLE (EXEC or DONE) ignored, no side effect.
REQ-020 ADD/AND/NOT/PASS_A, reserved, and SLL/SRA with B[SW-1:0]=0: IDLE->DONE at accept edge; done high the following cycle (latency 1).
REQ-021 ADD modulo 2^WIDTH, carry discarded; NOT = ~A; PASS_A = A; AND bitwise.
REQ-022 MUL: iterative shift-add, low WIDTH bits of A*B (sign-agnostic); exactly WIDTH EXEC cycles; DONE entered at accept edge + WIDTH.
REQ-023 SLL/SRA: shift A by s=B[SW-1:0], one bit per EXEC cycle; DONE entered at accept edge + s; SRA replicates MSB.
REQ-024 Reserved op 111: result = 0, no RF write, NZP unchanged, done still pulses.
REQ-025 On the edge entering DONE: result register loaded; if latched wb_en=1 and op legal, RF[dst] written and NZP updated the same edge.
REQ-026 NZP from result as signed: n=MSB, z=(result==0), p otherwise.
REQ-027 Write visible to an accept in the cycle after DONE (dst==src of next op reads new value; no stale data).
REQ-028 flush=1 in EXEC: next edge -> IDLE, no done, no RF write, result and NZP unchanged.
REQ-029 flush in IDLE blocks acceptance that edge; flush in DONE has no effect (write already committed).
REQ-030 RF has one internal write port; no external write path.

Reset
REQ-031 rst low forces immediately: state IDLE, busy=0, done=0, result=0, n=0 z=1 p=0, all RF entries 0, iteration counters 0.
REQ-032 Reset mid-operation aborts it; no write after release; first accept possible at first edge with rst high.

Verification (WIDTH=16, NREGS=8)
REQ-033 rst low during MUL EXEC -> busy=0, done=0, result=0x0000, nzp=010, dbg_data=0 for R0..R7; no later write.
REQ-034 ADD src_a=R0, imm=0x0005, imm_sel=1, dst=R1, wb_en=1 -> done one cycle after accept, result=0x0005, nzp=001, RF[1]=0x0005.
REQ-035 MUL R1(0x0005) x imm 0xFFFD, dst=R2 -> done exactly 17 cycles after accept edge cycle (16 EXEC), result=0xFFF1, nzp=100, RF[2]=0xFFF1.
REQ-036 SRA A=0x8000, s=4 -> done after 4 EXEC cycles, result=0xF800; SLL s=0 of 0x1234 -> latency 1, result=0x1234.
REQ-037 start held high through a MUL -> only one accept; flush on 5th EXEC cycle -> no done, RF[dst] and NZP unchanged, IDLE next cycle.
REQ-038 op=111 with wb_en=1 -> done pulses, result=0x0000, RF and NZP unchanged.

Source files
------------

// File: rtl/punc_exec_unit_if.sv
// ---------------------------------------------------------------------------
// punc_exec_unit_if
// Request/response bundle between a controller and the punc_exec_unit
// execute stage.
//
// Controller -> unit : start, op, src_a, src_b, dst, imm, imm_sel, wb_en,
//                      flush, dbg_addr
// Unit -> controller : busy, done, result, n, z, p, dbg_data
//
// Modports: master = controller side, slave = execute unit side.
// ---------------------------------------------------------------------------
interface punc_exec_unit_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
);
    localparam int AW = $clog2(NREGS);

    logic             start;
    logic [2:0]       op;
    logic [AW-1:0]    src_a;
    logic [AW-1:0]    src_b;
    logic [AW-1:0]    dst;
    logic [WIDTH-1:0] imm;
    logic             imm_sel;
    logic             wb_en;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             n;
    logic             z;
    logic             p;
    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    modport master (
        output start, op, src_a, src_b, dst, imm, imm_sel, wb_en, flush, dbg_addr,
        input  busy, done, result, n, z, p, dbg_data
    );

    modport slave (
        input  start, op, src_a, src_b, dst, imm, imm_sel, wb_en, flush, dbg_addr,
        output busy, done, result, n, z, p, dbg_data
    );
endinterface

// File: rtl/punc_exec_unit.sv
// ---------------------------------------------------------------------------
// punc_exec_unit
// Execute stage with a private register file. A request is accepted in IDLE;
// simple ops complete in one cycle, MUL runs an iterative shift-add over
// WIDTH cycles and SLL/SRA shift one bit per cycle. Completion loads the
// result register and, when enabled, writes back to the register file and
// updates the N/Z/P condition codes.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : punc_exec_unit_if.slave
//          in : start, op, src_a, src_b, dst, imm, imm_sel, wb_en, flush,
//               dbg_addr
//          out: busy, done, result, n, z, p, dbg_data (dbg_data is a
//               combinational read of RF[dbg_addr])
// ---------------------------------------------------------------------------
module punc_exec_unit #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic            clk,
    input  logic            rst,
    punc_exec_unit_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_SLL  = 3'b101;
    localparam logic [2:0] OP_SRA  = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             n_q;
    logic             z_q;
    logic             p_q;

    logic [WIDTH-1:0] rf [NREGS];

    // Latched request for multi-cycle ops
    logic [2:0]       op_q;
    logic [AW-1:0]    dst_q;
    logic             wb_q;
    logic [WIDTH-1:0] mcand_q;   // MUL multiplicand, or the value being shifted
    logic [WIDTH-1:0] mplier_q;  // MUL multiplier, consumed LSB first
    logic [WIDTH-1:0] acc_q;     // MUL partial product
    logic [CW-1:0]    cnt_q;     // remaining EXEC iterations

    // Operand fetch
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [SW-1:0]    sh_amt;
    logic             accept;
    logic             one_cycle;

    // Iteration step and commit
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] step_val;
    logic             commit_en;
    logic             commit_wr;
    logic [AW-1:0]    commit_dst;
    logic [WIDTH-1:0] commit_val;

    function automatic logic [WIDTH-1:0] sra_step(input logic [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] sv;
        sv = $signed(v);
        return $unsigned(sv >>> 1);
    endfunction

    // Result of every op that completes at the accept edge. SLL/SRA only
    // reach here with a zero shift amount, so they pass A through.
    function automatic logic [WIDTH-1:0] alu_single(input logic [2:0]       o,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (o)
            OP_ADD:  r = a + b;
            OP_AND:  r = a & b;
            OP_NOT:  r = ~a;
            OP_PASS: r = a;
            OP_SLL:  r = a;
            OP_SRA:  r = a;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign opa    = rf[bus.src_a];
    assign opb    = bus.imm_sel ? bus.imm : rf[bus.src_b];
    assign sh_amt = opb[SW-1:0];
    assign accept = (state == IDLE) && bus.start && !bus.flush;

    assign one_cycle = (bus.op != OP_MUL) &&
                       !(((bus.op == OP_SLL) || (bus.op == OP_SRA)) && (sh_amt != '0));

    // Stage: one EXEC iteration
    always_comb begin
        mul_acc  = acc_q + (mplier_q[0] ? mcand_q : '0);
        step_val = mcand_q;
        case (op_q)
            OP_MUL:  step_val = mul_acc;
            OP_SLL:  step_val = mcand_q << 1;
            OP_SRA:  step_val = sra_step(mcand_q);
            default: step_val = mcand_q;
        endcase
    end

    // Stage: commit on the edge that enters DONE
    always_comb begin
        commit_en  = 1'b0;
        commit_wr  = 1'b0;
        commit_dst = bus.dst;
        commit_val = '0;
        if (accept && one_cycle) begin
            commit_en  = 1'b1;
            commit_wr  = bus.wb_en && (bus.op != OP_RSV);
            commit_dst = bus.dst;
            commit_val = alu_single(bus.op, opa, opb);
        end else if ((state == EXEC) && !bus.flush && (cnt_q == CW'(1))) begin
            commit_en  = 1'b1;
            commit_wr  = wb_q;
            commit_dst = dst_q;
            commit_val = step_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b1;
            p_q      <= 1'b0;
            op_q     <= OP_ADD;
            dst_q    <= '0;
            wb_q     <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        op_q   <= bus.op;
                        dst_q  <= bus.dst;
                        wb_q   <= bus.wb_en && (bus.op != OP_RSV);
                        if (one_cycle) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state    <= EXEC;
                            mcand_q  <= opa;
                            mplier_q <= opb;
                            acc_q    <= '0;
                            cnt_q    <= (bus.op == OP_MUL) ? CW'(WIDTH) : CW'(sh_amt);
                        end
                    end
                end
                EXEC: begin
                    if (bus.flush) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        cnt_q  <= '0;
                    end else begin
                        mcand_q  <= (op_q == OP_MUL) ? (mcand_q << 1) : step_val;
                        mplier_q <= mplier_q >> 1;
                        acc_q    <= mul_acc;
                        cnt_q    <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase

            if (commit_en) begin
                result_q <= commit_val;
            end
            if (commit_wr) begin
                rf[commit_dst] <= commit_val;
                n_q <= commit_val[WIDTH-1];
                z_q <= (commit_val == '0);
                p_q <= !commit_val[WIDTH-1] && (commit_val != '0);
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.n        = n_q;
    assign bus.z        = z_q;
    assign bus.p        = p_q;
    assign bus.dbg_data = rf[bus.dbg_addr];

endmodule

// File: tb/tb_punc_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_punc_exec_unit
// Directed stimulus for punc_exec_unit (WIDTH=16, NREGS=8). Expected
// result/NZP pairs are queued when a request is issued and checked by an
// independent monitor whenever done is seen.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_punc_exec_unit;
    localparam int WIDTH = 16;
    localparam int NREGS = 8;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_SLL  = 3'b101;
    localparam logic [2:0] OP_SRA  = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  nzp;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t sb_q[$];

    punc_exec_unit_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

    punc_exec_unit #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rf(input int idx, input logic [15:0] exp);
        bus.dbg_addr = idx[2:0];
        #0.1;
        check($sformatf("rf[%0d]", idx), {16'h0, bus.dbg_data}, {16'h0, exp});
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst && bus.done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got result=0x%0h with no request outstanding", bus.result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (bus.result !== e.res || {bus.n, bus.z, bus.p} !== e.nzp) begin
                    errors++;
                    $display("FAIL done_result: got res=0x%0h nzp=%b expected res=0x%0h nzp=%b",
                             bus.result, {bus.n, bus.z, bus.p}, e.res, e.nzp);
                end
            end
        end
    end

    task automatic drive_req(input logic [2:0] op_i, input int sa, input int sb, input int d,
                             input logic [15:0] imm_i, input logic sel, input logic wb);
        bus.op      = op_i;
        bus.src_a   = sa[2:0];
        bus.src_b   = sb[2:0];
        bus.dst     = d[2:0];
        bus.imm     = imm_i;
        bus.imm_sel = sel;
        bus.wb_en   = wb;
        bus.start   = 1'b1;
    endtask

    // Issue one request, measure latency from the accept edge to done, then
    // check that done is a single-cycle pulse and the unit is idle again.
    task automatic do_op(input string name, input logic [2:0] op_i, input int sa, input int sb,
                         input int d, input logic [15:0] imm_i, input logic sel, input logic wb,
                         input logic [15:0] exp_res, input logic [2:0] exp_nzp,
                         input int exp_lat, input bit hold);
        int lat;
        @(posedge clk); #1;
        drive_req(op_i, sa, sb, d, imm_i, sel, wb);
        sb_q.push_back('{res: exp_res, nzp: exp_nzp});
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({name, "_pulse"}, {30'h0, bus.done, bus.busy}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        bus.start = 1'b0; bus.op = OP_ADD; bus.src_a = '0; bus.src_b = '0; bus.dst = '0;
        bus.imm = '0; bus.imm_sel = 1'b0; bus.wb_en = 1'b0; bus.flush = 1'b0; bus.dbg_addr = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("reset_busy_done", {30'h0, bus.busy, bus.done}, 32'h0);
        check("reset_result", {16'h0, bus.result}, 32'h0);
        check("reset_nzp", {29'h0, bus.n, bus.z, bus.p}, 32'b010);
        for (int i = 0; i < NREGS; i++) check_rf(i, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        do_op("add_imm",   OP_ADD,  0, 0, 1, 16'h0005, 1'b1, 1'b1, 16'h0005, 3'b001, 1,  1'b0);
        check_rf(1, 16'h0005);
        do_op("mul",       OP_MUL,  1, 0, 2, 16'hFFFD, 1'b1, 1'b1, 16'hFFF1, 3'b100, 17, 1'b0);
        check_rf(2, 16'hFFF1);
        do_op("ld_8000",   OP_ADD,  0, 0, 3, 16'h8000, 1'b1, 1'b1, 16'h8000, 3'b100, 1,  1'b0);
        do_op("sra4",      OP_SRA,  3, 0, 4, 16'h0004, 1'b1, 1'b1, 16'hF800, 3'b100, 5,  1'b0);
        check_rf(4, 16'hF800);
        do_op("ld_1234",   OP_ADD,  0, 0, 5, 16'h1234, 1'b1, 1'b1, 16'h1234, 3'b001, 1,  1'b0);
        do_op("sll0",      OP_SLL,  5, 0, 6, 16'h0000, 1'b1, 1'b1, 16'h1234, 3'b001, 1,  1'b0);
        do_op("sll3",      OP_SLL,  5, 0, 7, 16'h0003, 1'b1, 1'b1, 16'h91A0, 3'b100, 4,  1'b0);
        check_rf(7, 16'h91A0);
        do_op("reserved",  OP_RSV,  5, 0, 1, 16'h0000, 1'b1, 1'b1, 16'h0000, 3'b100, 1,  1'b0);
        check_rf(1, 16'h0005);
        do_op("and_reg",   OP_AND,  2, 5, 7, 16'h0000, 1'b0, 1'b1, 16'h1230, 3'b001, 1,  1'b0);
        check_rf(7, 16'h1230);
        do_op("not_nowb",  OP_NOT,  0, 0, 6, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 3'b001, 1,  1'b0);
        check_rf(6, 16'h1234);
        do_op("add_zero",  OP_ADD,  0, 0, 0, 16'h0000, 1'b1, 1'b1, 16'h0000, 3'b010, 1,  1'b0);
        do_op("pass_a",    OP_PASS, 4, 0, 3, 16'h0000, 1'b1, 1'b1, 16'hF800, 3'b100, 1,  1'b0);
        check_rf(3, 16'hF800);
        do_op("add_carry", OP_ADD,  1, 0, 1, 16'hFFFB, 1'b1, 1'b1, 16'h0000, 3'b010, 1,  1'b0);
        do_op("fwd1",      OP_ADD,  7, 0, 7, 16'h0010, 1'b1, 1'b1, 16'h1240, 3'b001, 1,  1'b0);
        do_op("fwd2",      OP_ADD,  7, 0, 7, 16'h0010, 1'b1, 1'b1, 16'h1250, 3'b001, 1,  1'b0);
        do_op("mul_hold",  OP_MUL,  5, 0, 6, 16'h0002, 1'b1, 1'b1, 16'h2468, 3'b001, 17, 1'b1);
        check_rf(6, 16'h2468);

        // Flush on the 5th EXEC cycle, start held high throughout
        @(posedge clk); #1;
        drive_req(OP_MUL, 2, 0, 2, 16'h0003, 1'b1, 1'b1);
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        check("flush_idle", {30'h0, bus.busy, bus.done}, 32'h0);
        repeat (20) @(posedge clk);
        #1;
        check_rf(2, 16'hFFF1);
        check("flush_nzp", {29'h0, bus.n, bus.z, bus.p}, 32'b001);
        check("flush_result", {16'h0, bus.result}, 32'h2468);

        // Flush in IDLE blocks acceptance
        @(posedge clk); #1;
        drive_req(OP_ADD, 0, 0, 3, 16'h0001, 1'b1, 1'b1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_idle_block", {30'h0, bus.busy, bus.done}, 32'h0);
        check_rf(3, 16'hF800);

        // Reset during MUL EXEC
        @(posedge clk); #1;
        drive_req(OP_MUL, 5, 0, 2, 16'h0003, 1'b1, 1'b1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_mid_busy_done", {30'h0, bus.busy, bus.done}, 32'h0);
        check("rst_mid_result", {16'h0, bus.result}, 32'h0);
        check("rst_mid_nzp", {29'h0, bus.n, bus.z, bus.p}, 32'b010);
        for (int i = 0; i < NREGS; i++) check_rf(i, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        drive_req(OP_ADD, 0, 0, 1, 16'h0007, 1'b1, 1'b1);
        sb_q.push_back('{res: 16'h0007, nzp: 3'b001});
        rst = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("post_rst_accept_done", {31'h0, bus.done}, 32'h1);
        repeat (20) @(posedge clk);
        #1;
        check_rf(1, 16'h0007);
        check_rf(2, 16'h0000);
        check("post_rst_idle", {31'h0, bus.busy}, 32'h0);
        check("scoreboard_drained", sb_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
